stopwatch_count: RTL and testbench

Stopwatch data source that drives the dynamic six-digit segment display driver with `data`/`point`/`en`/`sign`, replacing the free-running demo counter. It debounces two active-low keys (start/pause, clear) and keeps minutes, seconds and centiseconds. It presents the time as a binary value whose decimal digits read MM.SS.cc on the display.

---
 rtl/stopwatch_count.sv | 118 +++++++++++
 tb/tb_stopwatch_count.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_count.sv
// stopwatch_count: debounced start/clear keys drive an MM.SS.cc stopwatch shown as a binary value on the six-digit display.
// Define STOPWATCH_LAP_EN to add the lap key, which freezes the displayed time while counting continues.
module stopwatch_count #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_start_n,
  input  logic        key_clr_n,
`ifdef STOPWATCH_LAP_EN
  input  logic        key_lap_n,
`endif
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        en,
  output logic        sign
);
  localparam int DB = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int TICK = CLK_FREQ / 100;
  localparam int DW = $clog2(DB + 1);
  localparam int TW = $clog2(TICK + 1);
`ifdef STOPWATCH_LAP_EN
  localparam int NK = 3;
`else
  localparam int NK = 2;
`endif
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic [NK-1:0] keys_n, press;
  logic [TW-1:0] tick_cnt;
  logic tick, clr;
  logic [6:0] cs;
  logic [5:0] sec, min;
  logic [19:0] live, shown;
`ifdef STOPWATCH_LAP_EN
  assign keys_n = {key_lap_n, key_clr_n, key_start_n};
`else
  assign keys_n = {key_clr_n, key_start_n};
`endif
  // the counter only runs while the synchronised level differs from the debounced one
  for (genvar k = 0; k < NK; k++) begin : g_key
    logic [1:0] sync;
    logic db;
    logic [DW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sync <= 2'b11;
        db <= 1'b1;
        cnt <= '0;
        press[k] <= 1'b0;
      end else begin
        sync <= {sync[0], keys_n[k]};
        press[k] <= 1'b0;
        if (sync[1] == db) cnt <= '0;
        else if (cnt == DW'(DB - 1)) begin
          db <= sync[1];
          cnt <= '0;
          press[k] <= ~sync[1];
        end else cnt <= cnt + DW'(1);
      end
  end
  assign tick = state == RUN && tick_cnt == TW'(TICK - 1);
  // clear is dropped in RUN, which also lets start win a simultaneous press there
  assign clr = press[1] && state != RUN;
  assign live = 20'(min) * 20'd10000 + 20'(sec) * 20'd100 + 20'(cs);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tick_cnt <= '0;
      cs <= '0;
      sec <= '0;
      min <= '0;
    end else if (clr) begin
      state <= IDLE;
      tick_cnt <= '0;
      cs <= '0;
      sec <= '0;
      min <= '0;
    end else begin
      if (press[0]) state <= state == RUN ? PAUSE : RUN;
      if (state == RUN) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        cs <= cs == 7'd99 ? 7'd0 : cs + 7'd1;
        if (cs == 7'd99) begin
          sec <= sec == 6'd59 ? 6'd0 : sec + 6'd1;
          if (sec == 6'd59) min <= min == 6'd59 ? 6'd0 : min + 6'd1;
        end
      end
    end
`ifdef STOPWATCH_LAP_EN
  logic freeze;
  logic [19:0] lap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      freeze <= 1'b0;
      lap <= '0;
    end else if (clr) freeze <= 1'b0;
    else if (press[2] && state == RUN) begin
      freeze <= ~freeze;
      if (!freeze) lap <= live;
    end
  assign shown = freeze ? lap : live;
`else
  assign shown = live;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      point <= '0;
      en <= 1'b0;
    end else begin
      data <= shown;
      point <= 6'b010100;
      en <= 1'b1;
    end
  assign sign = 1'b0;
endmodule

// File: tb/tb_stopwatch_count.sv
// tb_stopwatch_count: scoreboard bench; every change of data must match the next queued expectation.
module tb_stopwatch_count;
  localparam int TICK = 100;
  typedef struct {
    logic [19:0] v;
    bit gap;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b1, key_start_n = 1'b1, key_clr_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
  logic key_lap_n = 1'b1;
`endif
  logic [19:0] data;
  logic [5:0] point;
  logic en, sign;
  logic [5:0] f_min, f_sec;
  logic [6:0] f_cs;
  int checks = 0, errors = 0;
  longint cyc = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  stopwatch_count #(.CLK_FREQ(10000), .DEBOUNCE_MS(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_start_n(key_start_n),
    .key_clr_n(key_clr_n),
`ifdef STOPWATCH_LAP_EN
    .key_lap_n(key_lap_n),
`endif
    .data(data),
    .point(point),
    .en(en),
    .sign(sign)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic expect_data(input int v, input bit gap);
    q.push_back('{20'(v), gap});
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_data(input logic [19:0] v, input int budget);
    int n = 0;
    while (data !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_data", 32'(data), 32'(v));
  endtask
  task automatic press(input bit s, input bit c);
    key_start_n = !s;
    key_clr_n = !c;
    cycles(30);
    key_start_n = 1'b1;
    key_clr_n = 1'b1;
    cycles(30);
  endtask
`ifdef STOPWATCH_LAP_EN
  task automatic press_lap();
    key_lap_n = 1'b0;
    cycles(30);
    key_lap_n = 1'b1;
    cycles(30);
  endtask
`endif
  // call right after a tick so the forced value is not overwritten before release
  task set_time(input logic [5:0] m, input logic [5:0] s, input logic [6:0] c);
    f_min = m;
    f_sec = s;
    f_cs = c;
    force dut.min = f_min;
    force dut.sec = f_sec;
    force dut.cs = f_cs;
    @(posedge clk);
    #1;
    release dut.min;
    release dut.sec;
    release dut.cs;
    @(negedge clk);
  endtask
  initial begin
    logic [19:0] prev;
    longint last;
    exp_t e;
    prev = '0;
    last = 0;
    forever begin
      @(negedge clk);
      if (data !== prev) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got %0d, expected %0d", data, prev);
        end else begin
          e = q.pop_front();
          check("data_seq", 32'(data), 32'(e.v));
          if (e.gap) check("tick_gap", 32'(cyc - last), TICK);
        end
        prev = data;
        last = cyc;
      end
    end
  end
  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_data", 32'(data), 0);
    check("rst_point", 32'(point), 0);
    check("rst_en", 32'(en), 0);
    check("rst_sign", 32'(sign), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    check("first_point", 32'(point), 32'h14);
    check("first_en", 32'(en), 1);
    cycles(1000);
    check("idle_data", 32'(data), 0);
    check("idle_point", 32'(point), 32'h14);
    check("idle_en", 32'(en), 1);
    check("idle_sign", 32'(sign), 0);
    repeat (3) begin
      key_start_n = 1'b0;
      cycles(10);
      key_start_n = 1'b1;
      cycles(10);
    end
    cycles(300);
    check("bounce_ignored", 32'(data), 0);
    for (int i = 1; i <= 11; i++) expect_data(i, i > 1);
    key_start_n = 1'b0;
    wait_data(20'd1, 300);
    cycles(76);
    key_start_n = 1'b1;
    cycles(824);
    check("run_10", 32'(data), 10);
    cycles(100);
    check("run_11", 32'(data), 11);
    expect_data(12, 1'b1);
    press(1'b0, 1'b1);
    wait_data(20'd12, 100);
    press(1'b1, 1'b0);
    cycles(300);
    check("pause_frozen", 32'(data), 12);
    expect_data(13, 1'b0);
    expect_data(14, 1'b1);
    press(1'b1, 1'b0);
    wait_data(20'd14, 300);
    press(1'b1, 1'b0);
    cycles(200);
    check("pause_again", 32'(data), 14);
    expect_data(0, 1'b0);
    press(1'b0, 1'b1);
    wait_data(20'd0, 100);
    cycles(300);
    check("clear_idle", 32'(data), 0);
    expect_data(1, 1'b0);
    press(1'b1, 1'b0);
    wait_data(20'd1, 300);
    press(1'b1, 1'b0);
    expect_data(0, 1'b0);
    press(1'b1, 1'b1);
    wait_data(20'd0, 100);
    cycles(300);
    check("both_in_pause", 32'(data), 0);
    press(1'b1, 1'b1);
    cycles(300);
    check("both_in_idle", 32'(data), 0);
    expect_data(1, 1'b0);
    press(1'b1, 1'b0);
    wait_data(20'd1, 300);
    expect_data(99, 1'b0);
    expect_data(100, 1'b0);
    set_time(6'd0, 6'd0, 7'd99);
    wait_data(20'd100, 200);
    expect_data(595999, 1'b0);
    expect_data(0, 1'b0);
    set_time(6'd59, 6'd59, 7'd99);
    wait_data(20'd0, 200);
    expect_data(1, 1'b1);
    wait_data(20'd1, 200);
    expect_data(1234, 1'b0);
    set_time(6'd0, 6'd12, 7'd34);
    wait_data(20'd1234, 50);
    expect_data(0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(data), 0);
    check("async_rst_point", 32'(point), 0);
    check("async_rst_en", 32'(en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(300);
    check("post_rst_data", 32'(data), 0);
    check("post_rst_point", 32'(point), 32'h14);
`ifdef STOPWATCH_LAP_EN
    expect_data(1, 1'b0);
    press(1'b1, 1'b0);
    wait_data(20'd1, 300);
    expect_data(249, 1'b0);
    expect_data(250, 1'b0);
    set_time(6'd0, 6'd2, 7'd49);
    wait_data(20'd250, 200);
    press_lap();
    cycles(440);
    check("lap_hold", 32'(data), 250);
    expect_data(255, 1'b0);
    expect_data(256, 1'b0);
    press_lap();
    wait_data(20'd256, 200);
`endif
    cycles(10);
    check("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
